dcache_array_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array with tree-PLRU replacement, byte-enabled write hits, victim reporting for write-back, and a hardware flush sequencer. It sits between the D-cache controller and the data-memory interface. Compared with the 2-way, 1 KB data SRAM it adds configurable ways, sets and block size, a one-cycle registered request/response handshake, and a dirty-line flush/invalidate walk with back-pressure.

---
 rtl/dcache_array_nway.sv | 234 +++++++++++++++++++++++
 tb/tb_dcache_array_nway.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_array_nway.sv
// dcache_array_nway: N-way set-associative data-cache storage array.
//   Tree-PLRU replacement, byte-enabled write hits, victim reporting for
//   write-back and a flush sequencer that writes back dirty lines and
//   invalidates the whole array.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_op/req_addr/req_byte_en/req_wdata : request in
//   resp_valid/resp_hit/resp_data/resp_evict_*                : response, 1 cycle after accept
//   flush_start/flush_busy                                     : flush control
//   wb_valid/wb_ready/wb_addr/wb_data                          : flush write-back stream
//
// state      | meaning
// IDLE       | serving requests
// FLUSH_SCAN | inspecting line (f_idx, f_way); clean/invalid lines dropped
// FLUSH_WB   | dirty line presented on wb_*, waiting for wb_ready
module dcache_array_nway #(
  parameter int WAYS        = 2,
  parameter int SETS        = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int TAG_W       = 23,
  parameter int IDX_W       = $clog2(SETS),
  parameter int ADDR_W      = TAG_W + IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [BLOCK_BYTES-1:0]   req_byte_en,
  input  logic [BLOCK_BYTES*8-1:0] req_wdata,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [BLOCK_BYTES*8-1:0] resp_data,
  output logic                     resp_evict_dirty,
  output logic [ADDR_W-1:0]        resp_evict_addr,
  output logic [BLOCK_BYTES*8-1:0] resp_evict_data,
  input  logic                     flush_start,
  output logic                     flush_busy,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [BLOCK_BYTES*8-1:0] wb_data
);

  localparam int DATA_W = BLOCK_BYTES * 8;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LVL    = $clog2(WAYS);
  localparam int PL_W   = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, FLUSH_SCAN, FLUSH_WB} state_t;

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right);
  // a node bit of 0 points left. Way bits are consumed MSB first.
  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [PL_W-1:0] res;
    int node;
    res  = bits;
    node = 0;
    for (int l = LVL - 1; l >= 0; l--) begin
      res[node] = ~way[l];
      node      = 2 * node + 1 + int'(way[l]);
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] bits);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = LVL - 1; l >= 0; l--) begin
      v[l] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  state_t                 state;
  logic [IDX_W-1:0]       f_idx;
  logic [WAY_W-1:0]       f_way;

  logic                   r_valid;
  logic [1:0]             r_op;
  logic [ADDR_W-1:0]      r_addr;
  logic [BLOCK_BYTES-1:0] r_be;
  logic [DATA_W-1:0]      r_wdata;

  logic [DATA_W-1:0]      data_mem [WAYS][SETS];
  logic [TAG_W-1:0]       tag_mem  [WAYS][SETS];
  logic [SETS-1:0]        valid_q  [WAYS];
  logic [SETS-1:0]        dirty_q  [WAYS];
  logic [PL_W-1:0]        plru_q   [SETS];

  logic [TAG_W-1:0]       r_tag;
  logic [IDX_W-1:0]       r_idx;
  logic                   op_write, op_fill;
  logic                   hit, inv_found;
  logic [WAY_W-1:0]       hit_way, inv_way, vic_way, fill_way;
  logic [DATA_W-1:0]      merged;
  logic                   show_vic, last_way, last_line, f_dirty;

  assign r_tag    = r_addr[ADDR_W-1:IDX_W];
  assign r_idx    = r_addr[IDX_W-1:0];
  assign op_write = (r_op == 2'b01);
  assign op_fill  = (r_op == 2'b10);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][r_idx] && (tag_mem[w][r_idx] == r_tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][r_idx] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    vic_way  = inv_found ? inv_way : plru_victim(plru_q[r_idx]);
    fill_way = hit ? hit_way : vic_way;
  end

  always_comb begin
    merged = data_mem[hit_way][r_idx];
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      if (r_be[b]) merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  assign req_ready        = (state == IDLE) && !flush_start;
  assign show_vic         = r_valid && !hit;
  assign resp_valid       = r_valid;
  assign resp_hit         = r_valid && hit;
  assign resp_data        = (r_valid && hit) ? data_mem[hit_way][r_idx] : '0;
  assign resp_evict_dirty = show_vic && valid_q[vic_way][r_idx] && dirty_q[vic_way][r_idx];
  assign resp_evict_addr  = show_vic ? {tag_mem[vic_way][r_idx], r_idx} : '0;
  assign resp_evict_data  = show_vic ? data_mem[vic_way][r_idx] : '0;

  assign flush_busy = (state != IDLE);
  assign wb_valid   = (state == FLUSH_WB);
  assign wb_addr    = wb_valid ? {tag_mem[f_way][f_idx], f_idx} : '0;
  assign wb_data    = wb_valid ? data_mem[f_way][f_idx] : '0;

  assign last_way  = (f_way == WAY_W'(WAYS - 1));
  assign last_line = last_way && (f_idx == IDX_W'(SETS - 1));
  assign f_dirty   = valid_q[f_way][f_idx] && dirty_q[f_way][f_idx];

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      r_op    <= req_op;
      r_addr  <= req_addr;
      r_be    <= req_byte_en;
      r_wdata <= req_wdata;
    end
  end

  // Array updates land on the edge that ends the response cycle, so a request
  // accepted on that same edge already looks up the new contents.
  always_ff @(posedge clk) begin
    if (r_valid) begin
      if (op_fill) begin
        data_mem[fill_way][r_idx] <= r_wdata;
        tag_mem[fill_way][r_idx]  <= r_tag;
      end else if (op_write && hit) begin
        data_mem[hit_way][r_idx] <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      f_idx   <= '0;
      f_way   <= '0;
      r_valid <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      r_valid <= req_valid && req_ready;

      // Requests are never accepted outside IDLE, so this never overlaps the walk.
      if (r_valid) begin
        if (op_fill) begin
          valid_q[fill_way][r_idx] <= 1'b1;
          dirty_q[fill_way][r_idx] <= 1'b0;
          plru_q[r_idx]            <= plru_touch(plru_q[r_idx], fill_way);
        end else if (hit) begin
          if (op_write) dirty_q[hit_way][r_idx] <= 1'b1;
          plru_q[r_idx] <= plru_touch(plru_q[r_idx], hit_way);
        end
      end

      case (state)
        IDLE: begin
          if (flush_start) begin
            state <= FLUSH_SCAN;
            f_idx <= '0;
            f_way <= '0;
          end
        end
        FLUSH_SCAN, FLUSH_WB: begin
          if (state == FLUSH_SCAN && f_dirty) begin
            state <= FLUSH_WB;
          end else if (state == FLUSH_SCAN || wb_ready) begin
            valid_q[f_way][f_idx] <= 1'b0;
            dirty_q[f_way][f_idx] <= 1'b0;
            if (last_way) begin
              f_way <= '0;
              f_idx <= f_idx + 1'b1;
            end else begin
              f_way <= f_way + 1'b1;
            end
            if (last_line) begin
              state <= IDLE;
              for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            end else begin
              state <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_array_nway.sv
module tb_dcache_array_nway;
  localparam int WAYS   = 2;
  localparam int SETS   = 32;
  localparam int BB     = 16;
  localparam int TAG_W  = 23;
  localparam int IDX_W  = 5;
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int DW     = BB * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [BB-1:0]     req_byte_en = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic              resp_valid, resp_hit, resp_evict_dirty;
  logic [DW-1:0]     resp_data, resp_evict_data;
  logic [ADDR_W-1:0] resp_evict_addr;
  logic              flush_start = 1'b0;
  logic              flush_busy, wb_valid;
  logic              wb_ready = 1'b0;
  logic [ADDR_W-1:0] wb_addr;
  logic [DW-1:0]     wb_data;

  always #5 clk = ~clk;

  dcache_array_nway #(.WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BB), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_byte_en(req_byte_en), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .resp_evict_dirty(resp_evict_dirty), .resp_evict_addr(resp_evict_addr),
    .resp_evict_data(resp_evict_data),
    .flush_start(flush_start), .flush_busy(flush_busy),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // Reference model: per-line contents plus, per set, the most recently used
  // way (-1 when nothing touched). With two ways the PLRU victim is simply the
  // way that was not used last.
  bit            m_valid [WAYS][SETS];
  bit            m_dirty [WAYS][SETS];
  logic [TAG_W-1:0] m_tag [WAYS][SETS];
  logic [DW-1:0] m_data  [WAYS][SETS];
  int            m_last  [SETS];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < SETS; s++) m_last[s] = -1;
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int tag, input int idx);
    return {TAG_W'(tag), IDX_W'(idx)};
  endfunction

  // Entered and left at 1 time unit after a rising edge; consecutive calls
  // therefore issue back-to-back requests.
  task automatic step_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [BB-1:0] be, input logic [DW-1:0] wd);
    int s_idx, hw, vw;
    logic [TAG_W-1:0] tag;
    s_idx = int'(addr[IDX_W-1:0]);
    tag   = addr[ADDR_W-1:IDX_W];
    hw = -1;
    vw = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[w][s_idx] && m_tag[w][s_idx] == tag && hw < 0) hw = w;
      if (!m_valid[w][s_idx] && vw < 0) vw = w;
    end
    if (vw < 0) vw = (m_last[s_idx] < 0) ? 0 : 1 - m_last[s_idx];

    chk("req_ready", DW'(req_ready), DW'(1'b1));
    req_valid = 1'b1; req_op = op; req_addr = addr; req_byte_en = be; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;

    chk("resp_valid", DW'(resp_valid), DW'(1'b1));
    chk("resp_hit", DW'(resp_hit), DW'(hw >= 0));
    chk("resp_data", resp_data, (hw >= 0) ? m_data[hw][s_idx] : '0);
    if (hw < 0) begin
      chk("evict_dirty", DW'(resp_evict_dirty), DW'(m_valid[vw][s_idx] && m_dirty[vw][s_idx]));
      if (m_valid[vw][s_idx]) begin
        chk("evict_addr", DW'(resp_evict_addr), DW'({m_tag[vw][s_idx], addr[IDX_W-1:0]}));
        chk("evict_data", resp_evict_data, m_data[vw][s_idx]);
      end
    end

    if (op == 2'b10) begin
      int fw;
      fw = (hw >= 0) ? hw : vw;
      m_valid[fw][s_idx] = 1'b1;
      m_dirty[fw][s_idx] = 1'b0;
      m_tag[fw][s_idx]   = tag;
      m_data[fw][s_idx]  = wd;
      m_last[s_idx]      = fw;
    end else if (hw >= 0) begin
      if (op == 2'b01) begin
        for (int b = 0; b < BB; b++)
          if (be[b]) m_data[hw][s_idx][8*b +: 8] = wd[8*b +: 8];
        m_dirty[hw][s_idx] = 1'b1;
      end
      m_last[s_idx] = hw;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_resp_valid", DW'(resp_valid), DW'(1'b0));
    end
  endtask

  task automatic do_flush(input int hold, input bit with_req);
    logic [ADDR_W-1:0] qa[$];
    logic [DW-1:0]     qd[$];
    int t;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[w][s] && m_dirty[w][s]) begin
          qa.push_back({m_tag[w][s], IDX_W'(s)});
          qd.push_back(m_data[w][s]);
        end

    flush_start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_op = 2'b00; req_addr = '0;
    end
    #1;
    if (with_req) chk("prio_req_ready", DW'(req_ready), DW'(1'b0));
    @(posedge clk); #1;
    flush_start = 1'b0;
    req_valid   = 1'b0;
    chk("flush_busy_on", DW'(flush_busy), DW'(1'b1));
    chk("ready_in_flush", DW'(req_ready), DW'(1'b0));
    if (with_req) chk("prio_no_resp", DW'(resp_valid), DW'(1'b0));

    for (int i = 0; i < qa.size(); i++) begin
      t = 0;
      while (!wb_valid && flush_busy && t < 4 * WAYS * SETS) begin
        @(posedge clk); #1;
        t++;
      end
      chk("wb_valid", DW'(wb_valid), DW'(1'b1));
      if (!wb_valid) break;
      chk("wb_addr", DW'(wb_addr), DW'(qa[i]));
      chk("wb_data", wb_data, qd[i]);
      repeat (hold) begin
        @(posedge clk); #1;
        chk("wb_hold_valid", DW'(wb_valid), DW'(1'b1));
        chk("wb_hold_addr", DW'(wb_addr), DW'(qa[i]));
      end
      wb_ready = 1'b1;
      @(posedge clk); #1;
      wb_ready = 1'b0;
    end

    t = 0;
    while (flush_busy && t < 4 * WAYS * SETS) begin
      if (wb_valid) begin
        chk("extra_wb", DW'(wb_valid), DW'(1'b0));
        wb_ready = 1'b1;
      end
      @(posedge clk); #1;
      wb_ready = 1'b0;
      t++;
    end
    chk("flush_busy_off", DW'(flush_busy), DW'(1'b0));
    chk("ready_after_flush", DW'(req_ready), DW'(1'b1));
    model_reset();
  endtask

  initial begin
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr, x_addr, y_addr, p_addr, q_addr;
    logic [DW-1:0] fill_d;
    int t;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", DW'(resp_valid), DW'(1'b0));
    chk("rst_resp_hit", DW'(resp_hit), DW'(1'b0));
    chk("rst_resp_data", resp_data, '0);
    chk("rst_flush_busy", DW'(flush_busy), DW'(1'b0));
    chk("rst_wb_valid", DW'(wb_valid), DW'(1'b0));
    rst = 1'b1;
    idle(1);

    // Directed scenario from reset.
    a_addr = mk_addr(32'h12, 3);
    b_addr = mk_addr(32'h34, 3);
    c_addr = mk_addr(32'h56, 3);
    fill_d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step_req(2'b00, 28'h0000003, '0, '0);
    chk("first_miss", DW'(resp_hit), DW'(1'b0));
    step_req(2'b10, a_addr, '0, fill_d);
    step_req(2'b00, a_addr, '0, '0);
    chk("fill_readback", resp_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    step_req(2'b01, a_addr, 16'h0001, 128'h5A);
    step_req(2'b00, a_addr, '0, '0);
    chk("fwd_merge", resp_data, 128'h00112233_44556677_8899AABB_CCDDEE5A);
    step_req(2'b10, b_addr, '0, 128'hB0B0);
    chk("fill_b_evict_dirty", DW'(resp_evict_dirty), DW'(1'b0));
    step_req(2'b10, c_addr, '0, 128'hC0C0);
    chk("fill_c_evict_dirty", DW'(resp_evict_dirty), DW'(1'b1));
    chk("fill_c_evict_addr", DW'(resp_evict_addr), DW'(a_addr));
    chk("fill_c_evict_byte0", DW'(resp_evict_data[7:0]), DW'(8'h5A));
    step_req(2'b11, c_addr, '0, '0);
    idle(2);

    // Randomized traffic over a small address pool to force hits and evictions.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      step_req(2'($urandom_range(0, 3)),
               mk_addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
               BB'($urandom_range(0, 65535)),
               {$urandom, $urandom, $urandom, $urandom});
    end
    do_flush(1, 1'b1);
    step_req(2'b00, c_addr, '0, '0);

    // Two dirty lines; the last write is still pending when the flush starts.
    x_addr = mk_addr(7, 5);
    y_addr = mk_addr(8, 9);
    step_req(2'b10, x_addr, '0, 128'h1111);
    step_req(2'b10, y_addr, '0, 128'h2222);
    step_req(2'b01, x_addr, 16'hFFFF, 128'hAAAA_BBBB);
    step_req(2'b01, y_addr, 16'h00F0, {$urandom, $urandom, $urandom, $urandom});
    do_flush(3, 1'b0);
    step_req(2'b00, x_addr, '0, '0);
    step_req(2'b00, y_addr, '0, '0);

    // Reset while a write-back is being held.
    p_addr = mk_addr(9, 1);
    q_addr = mk_addr(10, 2);
    step_req(2'b10, p_addr, '0, 128'h3333);
    step_req(2'b01, p_addr, 16'h00FF, 128'h4444);
    step_req(2'b10, q_addr, '0, 128'h5555);
    step_req(2'b01, q_addr, 16'hFF00, 128'h6666_0000_0000_0000_0000);
    flush_start = 1'b1;
    @(posedge clk); #1;
    flush_start = 1'b0;
    t = 0;
    while (!wb_valid && t < 4 * WAYS * SETS) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_wb_valid", DW'(wb_valid), DW'(1'b1));
    chk("mid_wb_addr", DW'(wb_addr), DW'(p_addr));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_wb_valid", DW'(wb_valid), DW'(1'b0));
    chk("abort_flush_busy", DW'(flush_busy), DW'(1'b0));
    chk("abort_resp_valid", DW'(resp_valid), DW'(1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk("abort_req_ready", DW'(req_ready), DW'(1'b1));
    step_req(2'b00, p_addr, '0, '0);
    step_req(2'b00, q_addr, '0, '0);
    step_req(2'b00, x_addr, '0, '0);
    step_req(2'b10, q_addr, '0, 128'h7777);
    step_req(2'b00, q_addr, '0, '0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
